stim_rr_scheduler: RTL and testbench
====================================

Name: stim_rr_scheduler

Overview:
- Sequences and shares one DUT stimulus input port (valid/ready/data) between NUM_REQ independent stimulus requesters in the testbench environment.
- Grants are round-robin and burst-based, and each burst is bounded by MAX_BURST beats.
- A no-progress watchdog releases a hung grant and flags the error.
- Clocked by the testbench global clock; released from reset by the global reset.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, stimulus data width
MAX_BURST, 8, max beats per grant (1..256)
TIMEOUT, 1024, consecutive no-handshake cycles in a grant before forced release (>=2)

Ports:
clk  in  1  global clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by req_valid
req_data  in  NUM_REQ*DATA_W  packed per-requester data; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
dut_valid  out  1  beat valid to DUT
dut_data  out  DATA_W  beat data to DUT
dut_ready  in  1  DUT accept
grant_id  out  $clog2(NUM_REQ)  index of current/last grantee
busy  out  1  high while in XFER
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; grant_id=0; last_grant=NUM_REQ-1, so the first grant goes to requester 0.
  - beat_cnt=0; to_cnt=0; timeout_err=0.
  - dut_valid=0; req_ready=0; busy=0.
- FSM states: IDLE and XFER.
- IDLE:
  - When any req_valid is high, pick the first requester with req_valid high, searching cyclically from last_grant+1.
  - Register the pick into grant_id, clear beat_cnt and to_cnt, and go to XFER.
  - If no req_valid is high, stay in IDLE.
- XFER outputs (combinational from registered state):
  - dut_valid = req_valid[grant_id]
  - dut_data = req_data slice for grant_id
  - req_ready[grant_id] = dut_ready; all other req_ready bits = 0
  - In IDLE, dut_valid=0 and req_ready=0.
- Handshake: a beat transfers when dut_valid && dut_ready.
  - Each beat increments beat_cnt and clears to_cnt.
  - A grantee may drop req_valid mid-burst; the grant is held.
- Burst end: on a beat with req_last=1, or a beat with beat_cnt==MAX_BURST-1.
  - Go to IDLE and set last_grant=grant_id.
- Watchdog: each XFER cycle without a handshake increments to_cnt.
  - When to_cnt reaches TIMEOUT-1 and a further no-handshake cycle occurs, set timeout_err=1 (sticky until reset), set last_grant=grant_id, and go to IDLE.
- Latency:
  - First request to dut_valid: 1 cycle.
  - Burst end to next grant's dut_valid: 2 cycles. The mandatory IDLE bubble is one cycle with dut_valid=0.
- Fairness: the grantee of the burst just ended has lowest priority in the next arbitration.
- Simultaneous events: a handshake on the cycle the watchdog would expire counts as progress; no timeout.
- Reset mid-burst: outputs drop asynchronously to their reset values. The partial burst is abandoned; the requester is responsible for restarting it.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits; to_cnt is $clog2(TIMEOUT+1) bits.
  - Neither counter wraps; each is cleared on grant.

Decomposition:
- Package stim_sched_pkg holds:
  - the state enum typedef (IDLE, XFER)
  - grant index typedef sized by $clog2(NUM_REQ)
  - default parameter constants
- Sub-module rr_pick: combinational round-robin priority search.
  - Inputs: req vector and last_grant.
  - Outputs: winner index and any_req.
  - Instantiated once.

Test Plan:
- Single requester (req 2), 3-beat burst with req_last on beat 3, dut_ready=1 -> grant_id=2; dut_valid high on cycles 1–3; data matches req 2; busy drops after beat 3.
- All 4 requesters continuously valid, bursts of 2 -> grant order 0,1,2,3,0; exactly one dut_valid=0 cycle between bursts.
- MAX_BURST=8, requester 1 never asserts req_last -> forced release after beat 8; requester 1 regranted only after the others are serviced.
- dut_ready held 0 with TIMEOUT=16 -> timeout_err rises after 16 stalled XFER cycles; state returns to IDLE; flag stays high through subsequent traffic until reset.
- dut_ready toggling so a handshake lands on cycle TIMEOUT -> no timeout_err; burst completes normally.
- Reset asserted mid-burst between clock edges -> dut_valid, req_ready, busy go low immediately. After release, the first grant goes to requester 0 even if requester 3 was active before.

Source files
------------

// File: rtl/stim_sched_pkg.sv
// Shared types and default constants for the round-robin stimulus scheduler.
package stim_sched_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 8;
    localparam int DEF_TIMEOUT   = 1024;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] grant_idx_t;

endpackage

// File: rtl/stim_rr_scheduler_rr_pick.sv
// Combinational round-robin search: first asserted request after last_grant, cyclically.
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [GW-1:0] winner,
    output logic          any_req
);

    logic found_s;
    int   idx_s;

    // Scan from last_grant+1 so the previous grantee is visited last.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 1; i <= N; i++) begin
            idx_s = (int'(last_grant) + i) % N;
            if (!found_s && req[idx_s]) begin
                winner  = GW'(idx_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/stim_rr_scheduler.sv
// Shares one DUT stimulus port among NUM_REQ requesters with round-robin,
// burst-bounded grants and a no-progress watchdog.
module stim_rr_scheduler
    import stim_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       dut_valid,
    output logic [DATA_W-1:0]          dut_data,
    input  logic                       dut_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    sched_state_t   state_r;
    sched_state_t   state_nxt_s;
    logic [GW-1:0]  grant_r;
    logic [GW-1:0]  last_grant_r;
    logic [BW-1:0]  beat_cnt_r;
    logic [TW-1:0]  to_cnt_r;
    logic           timeout_err_r;
    logic [GW-1:0]  pick_s;
    logic           any_req_s;
    logic           hs_s;
    logic           burst_end_s;
    logic           expire_s;

    rr_pick #(.N(NUM_REQ), .GW(GW)) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .winner     (pick_s),
        .any_req    (any_req_s)
    );

    // A handshake on the expiry cycle counts as progress, so expiry requires !hs_s.
    assign hs_s        = (state_r == XFER) && req_valid[grant_r] && dut_ready;
    assign burst_end_s = hs_s && (req_last[grant_r] || (beat_cnt_r == BEAT_LAST));
    assign expire_s    = (state_r == XFER) && !hs_s && (to_cnt_r == TO_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) state_nxt_s = XFER;
                else           state_nxt_s = IDLE;
            end
            XFER: begin
                if (burst_end_s || expire_s) state_nxt_s = IDLE;
                else                         state_nxt_s = XFER;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant bookkeeping, beat/stall counters and the sticky watchdog flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_r       <= '0;
            last_grant_r  <= GW'(NUM_REQ - 1);
            beat_cnt_r    <= '0;
            to_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        grant_r    <= pick_s;
                        beat_cnt_r <= '0;
                        to_cnt_r   <= '0;
                    end
                end
                XFER: begin
                    if (hs_s) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                        to_cnt_r   <= '0;
                        if (burst_end_s) last_grant_r <= grant_r;
                    end else if (expire_s) begin
                        timeout_err_r <= 1'b1;
                        last_grant_r  <= grant_r;
                    end else begin
                        to_cnt_r <= to_cnt_r + TW'(1);
                    end
                end
                default: begin
                    grant_r <= grant_r;
                end
            endcase
        end
    end

    // Port mux; driven from registered state so a reset drops it immediately.
    always_comb begin
        dut_valid = 1'b0;
        dut_data  = '0;
        req_ready = '0;
        busy      = 1'b0;
        if (state_r == XFER) begin
            dut_valid          = req_valid[grant_r];
            dut_data           = req_data[int'(grant_r)*DATA_W +: DATA_W];
            req_ready[grant_r] = dut_ready;
            busy               = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

    assign grant_id    = grant_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_stim_rr_scheduler.sv
// Directed self-checking bench for stim_rr_scheduler (4 requesters, MAX_BURST=8, TIMEOUT=16).
module tb_stim_rr_scheduler;
    import stim_sched_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              dut_valid;
    logic [DW-1:0]     dut_data;
    logic              dut_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int blen[NR];
    int bcnt[NR];

    stim_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .dut_valid(dut_valid),
        .dut_data(dut_data), .dut_ready(dut_ready), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(int i, int c);
        return 32'hC0DE_0000 | (32'(i) << 8) | 32'(c);
    endfunction

    // Requester model: last marker and data from each requester's beat position.
    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_last[i] = (blen[i] != 0) && (bcnt[i] == blen[i] - 1);
            req_data[i*DW +: DW] = data_of(i, bcnt[i]);
        end
        #1;
    endtask

    task automatic account();
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i])
                bcnt[i] = (blen[i] != 0 && bcnt[i] + 1 == blen[i]) ? 0 : bcnt[i] + 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; dut_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin blen[i] = 0; bcnt[i] = 0; end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111; req_last = '0; req_data = '0; dut_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({dut_valid, busy, req_ready, grant_id, timeout_err} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b b=%b r=%b g=%0d e=%b exp all zero",
                     dut_valid, busy, req_ready, grant_id, timeout_err);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [8:0] exp_v;
        do_reset();
        blen[2] = 3;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) begin req_valid = 4'b0100; dut_ready = 1'b1; end
            if (k == 4) req_valid = 4'b0000;
            drive_inputs();
            if (k >= 1 && k <= 3) exp_v = {1'b1, 1'b1, 4'b0100, 2'd2, 1'b0};
            else if (k == 4)      exp_v = {1'b0, 1'b0, 4'b0000, 2'd2, 1'b0};
            else                  exp_v = {1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
            n_tests++;
            if ({dut_valid, busy, req_ready, grant_id, timeout_err} !== exp_v) begin
                n_fail++;
                $display("FAIL single_ctrl k=%0d got %b exp %b", k,
                         {dut_valid, busy, req_ready, grant_id, timeout_err}, exp_v);
            end
            if (k >= 1 && k <= 3) begin
                n_tests++;
                if (dut_data !== data_of(2, k - 1)) begin
                    n_fail++;
                    $display("FAIL single_data k=%0d got %h exp %h", k, dut_data, data_of(2, k - 1));
                end
            end
            account();
        end
    endtask

    task automatic test_round_robin();
        logic       ev;
        grant_idx_t eg;
        logic [3:0] er;
        int         m;
        do_reset();
        for (int i = 0; i < NR; i++) blen[i] = 2;
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            if (k == 0) begin req_valid = 4'b1111; dut_ready = 1'b1; end
            drive_inputs();
            m  = k - 1;
            ev = (k != 0) && (m % 3 != 2);
            eg = (k == 0) ? 2'd0 : grant_idx_t'((m / 3) % 4);
            er = ev ? (4'b0001 << eg) : 4'b0000;
            n_tests++;
            if ({dut_valid, busy, req_ready, grant_id} !== {ev, ev, er, eg}) begin
                n_fail++;
                $display("FAIL rr_order k=%0d got v=%b b=%b r=%b g=%0d exp v=%b r=%b g=%0d",
                         k, dut_valid, busy, req_ready, grant_id, ev, er, eg);
            end
            if (ev) begin
                n_tests++;
                if (dut_data !== data_of(int'(eg), m % 3)) begin
                    n_fail++;
                    $display("FAIL rr_data k=%0d got %h exp %h", k, dut_data, data_of(int'(eg), m % 3));
                end
            end
            account();
        end
    endtask

    task automatic test_max_burst();
        int         sg[6] = '{0, 1, 2, 3, 0, 1};
        int         sl[6] = '{2, 8, 2, 2, 2, 8};
        logic       xv[64];
        int         xg[64];
        int         pos;
        do_reset();
        blen[0] = 2; blen[1] = 0; blen[2] = 2; blen[3] = 2;
        xv[0] = 1'b0; xg[0] = 0; pos = 1;
        for (int b = 0; b < 6; b++) begin
            for (int j = 0; j < sl[b]; j++) begin xv[pos] = 1'b1; xg[pos] = sg[b]; pos++; end
            xv[pos] = 1'b0; xg[pos] = sg[b]; pos++;
        end
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            if (k == 0) begin req_valid = 4'b1111; dut_ready = 1'b1; end
            drive_inputs();
            n_tests++;
            if ({dut_valid, busy, grant_id} !== {xv[k], xv[k], 2'(xg[k])}) begin
                n_fail++;
                $display("FAIL max_burst k=%0d got v=%b b=%b g=%0d exp v=%b g=%0d",
                         k, dut_valid, busy, grant_id, xv[k], xg[k]);
            end
            account();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        blen[0] = 2;
        for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            if (k == 0) begin req_valid = 4'b0001; dut_ready = 1'b0; end
            if (k == 18) begin req_valid = 4'b0011; blen[1] = 2; dut_ready = 1'b1; end
            drive_inputs();
            if (k == 16) begin
                n_tests++;
                if ({busy, timeout_err} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL timeout_early got busy=%b err=%b exp busy=1 err=0", busy, timeout_err);
                end
            end
            if (k == 17) begin
                n_tests++;
                if ({busy, dut_valid, timeout_err} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL timeout_fire got busy=%b v=%b err=%b exp 0 0 1", busy, dut_valid, timeout_err);
                end
            end
            if (k == 21) begin
                n_tests++;
                if ({busy, grant_id} !== {1'b1, 2'd1}) begin
                    n_fail++;
                    $display("FAIL timeout_next_grant got busy=%b g=%0d exp busy=1 g=1", busy, grant_id);
                end
            end
            if (k == 26) begin
                n_tests++;
                if (timeout_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_sticky got %b exp 1", timeout_err);
                end
            end
            account();
        end
        do_reset();
        #1;
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear got %b exp 0", timeout_err);
        end
    endtask

    task automatic test_handshake_at_timeout();
        logic eb;
        do_reset();
        blen[0] = 2;
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            if (k == 0)  begin req_valid = 4'b0001; dut_ready = 1'b0; end
            if (k == 16) dut_ready = 1'b1;
            drive_inputs();
            eb = (k != 0) && (k != 18);
            n_tests++;
            if ({busy, timeout_err} !== {eb, 1'b0}) begin
                n_fail++;
                $display("FAIL hs_at_timeout k=%0d got busy=%b err=%b exp busy=%b err=0",
                         k, busy, timeout_err, eb);
            end
            account();
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            if (k == 0) begin req_valid = 4'b1000; dut_ready = 1'b1; end
            drive_inputs();
            if (k == 2) begin
                n_tests++;
                if ({busy, grant_id} !== {1'b1, 2'd3}) begin
                    n_fail++;
                    $display("FAIL midrst_pre got busy=%b g=%0d exp busy=1 g=3", busy, grant_id);
                end
            end
            account();
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({dut_valid, busy, req_ready, grant_id} !== 8'b0) begin
            n_fail++;
            $display("FAIL midrst_async got v=%b b=%b r=%b g=%0d exp all zero",
                     dut_valid, busy, req_ready, grant_id);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b1001;
        for (int i = 0; i < NR; i++) bcnt[i] = 0;
        drive_inputs();
        @(negedge clk);
        #1;
        n_tests++;
        if ({dut_valid, busy, req_ready, grant_id} !== {1'b1, 1'b1, 4'b0001, 2'd0}) begin
            n_fail++;
            $display("FAIL midrst_regrant got v=%b b=%b r=%b g=%0d exp v=1 b=1 r=0001 g=0",
                     dut_valid, busy, req_ready, grant_id);
        end
        n_tests++;
        if (dut_data !== data_of(0, 0)) begin
            n_fail++;
            $display("FAIL midrst_data got %h exp %h", dut_data, data_of(0, 0));
        end
        req_valid = 4'b0000;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; dut_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_timeout();
        test_handshake_at_timeout();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
